// File: rtl/data_mem_sized_pkg.sv
// Shared encodings for the sized data memory: access sizes, FSM states and
// the alignment rule used to reject accesses.
package data_mem_sized_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int LATENCY_MAX = 7;

  // Halfwords need an even address, words a 4-byte aligned one; code 11 is never legal.
  function automatic logic is_misaligned(input size_t sz, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_bank_be.sv
// Word-organised storage with per-byte write enables and combinational read.
// Each byte lane is its own array so a partial write touches only its lanes.
module mem_bank_be #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          lane_mem[idx] <= wdata[gi*8 +: 8];
        end
      end

      assign rdata[gi*8 +: 8] = lane_mem[idx];
    end
  endgenerate

endmodule

// File: rtl/data_mem_sized.sv
// Sized (byte/half/word) data memory with a fixed access latency: accepts a
// request in IDLE, waits LATENCY cycles, then performs it and pulses Ready.
module data_mem_sized
  import data_mem_sized_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        Ready,
  output logic        Misalign,
  output logic        Busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAT3 = 3'(LATENCY);

  state_t state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;

  size_t       size_reg;
  logic        uns_reg;
  logic        rd_op_reg;
  logic        wr_op_reg;
  logic [AW+1:0] addr_reg;
  logic [31:0] wd_reg;

  logic [31:0] rd_reg;
  logic        ready_reg;
  logic        misalign_reg;

  logic        accept;
  logic        err;
  logic        bank_we;
  logic [3:0]  bank_be;
  logic [31:0] bank_wdata;
  logic [31:0] bank_rdata;
  logic [31:0] lane_shift;
  logic [15:0] half_sel;
  logic [31:0] ext_data;
  logic        unused_addr_bits;

  // Bits above the word index are deliberately ignored so addresses wrap.
  assign unused_addr_bits = ^Addr[31:AW+2];

  assign accept = (state_reg == ST_IDLE) && (MemRead || MemWrite);
  assign err    = (rd_op_reg && wr_op_reg) || is_misaligned(size_reg, addr_reg[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = (LATENCY == 0) ? ST_DONE : ST_WAIT;
          cnt_next   = LAT3;
        end
      end
      ST_WAIT: begin
        if (cnt_reg <= 3'd1) begin
          state_next = ST_DONE;
          cnt_next   = 3'd0;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request fields are captured once so later input changes cannot disturb the access.
  always_ff @(posedge clk) begin
    if (accept) begin
      size_reg  <= size_t'(Size);
      uns_reg   <= Unsigned;
      rd_op_reg <= MemRead;
      wr_op_reg <= MemWrite;
      addr_reg  <= Addr[AW+1:0];
      wd_reg    <= WD;
    end
  end

  always_comb begin
    bank_be    = 4'b0000;
    bank_wdata = wd_reg;
    case (size_reg)
      SZ_BYTE: begin
        bank_be    = 4'b0001 << addr_reg[1:0];
        bank_wdata = {4{wd_reg[7:0]}};
      end
      SZ_HALF: begin
        bank_be    = addr_reg[1] ? 4'b1100 : 4'b0011;
        bank_wdata = {2{wd_reg[15:0]}};
      end
      SZ_WORD: bank_be = 4'b1111;
      default: bank_be = 4'b0000;
    endcase
  end

  assign bank_we = (state_reg == ST_DONE) && wr_op_reg && !err;

  mem_bank_be #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .be    (bank_be),
    .idx   (addr_reg[AW+1:2]),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  assign lane_shift = bank_rdata >> {addr_reg[1:0], 3'b000};
  assign half_sel   = addr_reg[1] ? bank_rdata[31:16] : bank_rdata[15:0];

  always_comb begin
    ext_data = bank_rdata;
    case (size_reg)
      SZ_BYTE: ext_data = uns_reg ? {24'd0, lane_shift[7:0]} : {{24{lane_shift[7]}}, lane_shift[7:0]};
      SZ_HALF: ext_data = uns_reg ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ext_data = bank_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_reg       <= 32'd0;
      ready_reg    <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      ready_reg    <= (state_reg == ST_DONE);
      misalign_reg <= (state_reg == ST_DONE) && err;
      if ((state_reg == ST_DONE) && rd_op_reg && !err) begin
        rd_reg <= ext_data;
      end
    end
  end

  assign RD       = rd_reg;
  assign Ready    = ready_reg;
  assign Misalign = misalign_reg;
  assign Busy     = (state_reg != ST_IDLE);

endmodule

// File: doc/data_mem_sized.md
DATA_MEM_SIZED -- requirements
Module: data_mem_sized

Interface
Parameters:
REQ-001: DEPTH_WORDS, default 1024, number of 32-bit words of storage; SHALL be a power of two, 16..65536.
REQ-002: LATENCY, default 1, number of extra wait cycles per access; SHALL be in the range 0..7.
Ports:
REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004: rst  input  1  reset, asynchronous, active-high.
REQ-005: MemRead  input  1  read request.
REQ-006: MemWrite  input  1  write request.
REQ-007: Size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008: Unsigned  input  1  read extension: 1 zero-extends, 0 sign-extends.
REQ-009: Addr  input  32  byte address.
REQ-010: WD  input  32  write data, right-aligned.
REQ-011: RD  output  32  read data, registered, right-aligned and extended.
REQ-012: Ready  output  1  one-cycle pulse that marks access completion.
REQ-013: Misalign  output  1  one-cycle pulse, concurrent with Ready, that flags a rejected access.
REQ-014: Busy  output  1  high while an accepted access is in flight.

Function
REQ-015: The FSM SHALL have the states IDLE, WAIT and DONE.
REQ-016: In IDLE, a request (MemRead or MemWrite high) SHALL be accepted at the clock edge.
REQ-017: On acceptance, Size, Unsigned, Addr, WD and the operation SHALL be latched.
REQ-018: Input changes after acceptance SHALL have no effect on the access in flight.
REQ-019: After acceptance, the FSM SHALL go to WAIT if LATENCY>0, otherwise directly to DONE.
REQ-020: WAIT SHALL last exactly LATENCY cycles, counted by a 3-bit down-counter.
REQ-021: In DONE, the access SHALL be performed, Ready SHALL pulse for one cycle, and the FSM SHALL return to IDLE.
REQ-022: Ready SHALL therefore assert LATENCY+1 cycles after the acceptance edge.
REQ-023: Requests presented while Busy SHALL be ignored and not queued.
REQ-024: Busy SHALL be high in WAIT and DONE.
REQ-025: A new request MAY be accepted in the cycle after DONE.
REQ-026: MemRead and MemWrite both high SHALL be rejected as an error: no memory change, RD unchanged, Misalign pulse with Ready.
REQ-027: Word index SHALL be Addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
REQ-028: Lane selection SHALL be little-endian: byte lane = Addr[1:0], halfword lane = Addr[1].
REQ-029: A halfword with Addr[0]=1, a word with Addr[1:0]!=0, or Size=11 SHALL be misaligned.
REQ-030: A misaligned write SHALL not modify memory; a misaligned read SHALL leave RD unchanged; both SHALL pulse Misalign with Ready.
REQ-031: A write SHALL modify only the addressed byte lanes, using byte enables derived from Size and Addr[1:0].
REQ-032: Byte writes SHALL store WD[7:0]; halfword writes SHALL store WD[15:0].
REQ-033: On a read, RD SHALL be loaded in the DONE cycle with the selected lane, extended to 32 bits per Unsigned.
REQ-034: RD SHALL hold its value until the next successful read.
REQ-035: Writes SHALL leave RD unchanged.
REQ-036: Memory contents SHALL be undefined at power-up and SHALL not be cleared by reset.

Reset
REQ-037: rst high SHALL immediately force state IDLE, the wait counter to 0, RD to 0x00000000, and Ready, Misalign and Busy to 0.
REQ-038: rst asserted mid-access SHALL abort the access; the write SHALL not occur unless DONE had already completed before rst.
REQ-039: The first request SHALL be accepted at the first rising edge after rst is deasserted.

Structure
REQ-040: A shared package SHALL hold the Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state encoding and the LATENCY maximum constant.
REQ-041: Storage SHALL be one sub-module, mem_bank_be: a DEPTH_WORDS x 32 array with synchronous write, 4-bit byte-enable and combinational read.
REQ-042: The FSM, the lane alignment and the extension logic SHALL reside in data_mem_sized.

Verification
REQ-043: Reset, then word write: LATENCY=1, write 0xDEADBEEF to Addr 0x10 -> Ready 2 cycles after acceptance; a word read of 0x10 returns 0xDEADBEEF.
REQ-044: Sub-word reads: after REQ-043, byte read of 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; halfword read of 0x10 signed -> 0xFFFFBEEF.
REQ-045: Byte-lane write: sb 0x55 at 0x11 -> subsequent word read of 0x10 returns 0xDEAD55EF.
REQ-046: Misalignment: word write to 0x12 -> Misalign=1 with Ready and memory unchanged; the same occurs for Size=11 and for MemRead=MemWrite=1.
REQ-047: Latency sweep: for LATENCY=0 and LATENCY=7 -> Ready at +1 and +8 cycles respectively; requests during Busy are ignored; Addr 4*DEPTH_WORDS+0x10 aliases 0x10.
REQ-048: Reset mid-access: rst in WAIT of a write -> Busy=0 and RD=0 immediately; the target word keeps its old value.
